seq_muldiv_alu: RTL and testbench

SEQ_MULDIV_ALU -- requirements
Module: seq_muldiv_alu

---
 rtl/seq_muldiv_alu_pkg.sv | 26 ++
 rtl/seq_muldiv_core.sv | 87 ++++++++
 rtl/seq_muldiv_alu.sv | 146 ++++++++++++++
 tb/tb_seq_muldiv_alu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_muldiv_alu_pkg.sv
// Shared definitions for the sequential multiply/divide ALU.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Holds the MIPS funct codes decoded by the ALU and the top-level FSM state type.
package seq_muldiv_alu_pkg;

   localparam logic [5:0] FN_SLL   = 6'd0;
   localparam logic [5:0] FN_SRL   = 6'd2;
   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MFLO  = 6'd18;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIVU  = 6'd27;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_AND   = 6'd36;
   localparam logic [5:0] FN_OR    = 6'd37;
   localparam logic [5:0] FN_SLT   = 6'd42;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative engine: unsigned shift-add multiply or restoring divide, one bit per cycle.
// Latency: start at edge k, done high in the cycle before edge k+WIDTH; result is valid while done.
// Backpressure: none; the caller must not pulse start while an operation is running.
//
// Ports: clk/reset (sync, active-low); start+isDiv+opA/opB launch an operation;
// done flags the final iteration; result = {HI,LO} as it will be after that iteration;
// divByZero is meaningful while done and tells the caller the divisor was zero.
module seq_muldiv_core
   import seq_muldiv_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               isDiv,
   input  logic [WIDTH-1:0]   opA,
   input  logic [WIDTH-1:0]   opB,
   output logic               done,
   output logic               divByZero,
   output logic [2*WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH);

   logic               active;
   logic               divMode;
   logic [CNT_W-1:0]   count;
   // accReg: upper product half / partial remainder.
   // shReg:  multiplier being consumed / dividend shifting out while quotient shifts in.
   logic [WIDTH-1:0]   accReg;
   logic [WIDTH-1:0]   shReg;
   logic [WIDTH-1:0]   opReg;

   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divShift;
   logic               divGe;
   logic [WIDTH-1:0]   nextAcc;
   logic [WIDTH-1:0]   nextSh;

   always_comb begin
      mulSum   = {1'b0, accReg} + (shReg[0] ? {1'b0, opReg} : '0);
      divShift = {accReg, shReg[WIDTH-1]};
      divGe    = (divShift >= {1'b0, opReg});
      if (divMode) begin
         // A successful subtract leaves a value below the divisor, so the low
         // WIDTH bits of the difference are the whole new remainder. A zero
         // divisor always subtracts, giving an all-ones quotient and the
         // dividend as remainder without any special casing.
         nextAcc = divGe ? (divShift[WIDTH-1:0] - opReg) : divShift[WIDTH-1:0];
         nextSh  = {shReg[WIDTH-2:0], divGe};
      end else begin
         nextAcc = mulSum[WIDTH:1];
         nextSh  = {mulSum[0], shReg[WIDTH-1:1]};
      end
   end

   assign done      = active && (count == CNT_W'(WIDTH-1));
   assign divByZero = divMode && (opReg == '0);
   assign result    = {nextAcc, nextSh};

   always_ff @(posedge clk) begin
      if (!reset) begin
         active  <= 1'b0;
         divMode <= 1'b0;
         count   <= '0;
         accReg  <= '0;
         shReg   <= '0;
         opReg   <= '0;
      end else if (start) begin
         active  <= 1'b1;
         divMode <= isDiv;
         count   <= '0;
         accReg  <= '0;
         shReg   <= opA;
         opReg   <= opB;
      end else if (active) begin
         accReg <= nextAcc;
         shReg  <= nextSh;
         count  <= count + CNT_W'(1);
         if (done) begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_muldiv_alu.sv
// MIPS-style ALU: single-cycle logic/arith/shift/MFHI/MFLO plus iterative MULTU/DIVU into HI/LO.
// Latency: single-cycle ops 1 edge (1 op/cycle); MULTU/DIVU WIDTH edges, then out_valid with Output=0.
// Backpressure: in_ready low while MUL/DIV runs; in_valid is ignored then and nothing is queued.
//
// Ports: clk, reset (sync, active-low); dataA/dataB/Signal request with in_valid/in_ready;
// Output/out_valid registered result pulse; busy during MUL/DIV; div_zero sticky;
// illegal pulses with out_valid for an unknown funct.
module seq_muldiv_alu
   import seq_muldiv_alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] Output,
   output logic             busy,
   output logic             div_zero,
   output logic             illegal
);

   state_t             state;
   state_t             stateNext;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;

   logic               accept;
   logic               isSingle;
   logic               isIllegal;
   logic               isMul;
   logic               isDiv;
   logic [WIDTH-1:0]   aluRes;

   logic               coreStart;
   logic               coreDone;
   logic               coreDivZero;
   logic [2*WIDTH-1:0] coreResult;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && in_ready;
   assign coreStart = accept && (isMul || isDiv);

   always_comb begin
      aluRes    = '0;
      isSingle  = 1'b1;
      isIllegal = 1'b0;
      isMul     = 1'b0;
      isDiv     = 1'b0;
      case (Signal)
         FN_AND:   aluRes = dataA & dataB;
         FN_OR:    aluRes = dataA | dataB;
         FN_ADD:   aluRes = dataA + dataB;
         FN_SUB:   aluRes = dataA - dataB;
         FN_SLT:   aluRes = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
         FN_SLL:   aluRes = dataA << dataB[SHAMT_W-1:0];
         FN_SRL:   aluRes = dataA >> dataB[SHAMT_W-1:0];
         FN_MFHI:  aluRes = hiReg;
         FN_MFLO:  aluRes = loReg;
         FN_MULTU: begin
            isSingle = 1'b0;
            isMul    = 1'b1;
         end
         FN_DIVU:  begin
            isSingle = 1'b0;
            isDiv    = 1'b1;
         end
         default:  isIllegal = 1'b1;
      endcase
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (accept && isMul) begin
               stateNext = MUL;
            end else if (accept && isDiv) begin
               stateNext = DIV;
            end
         end
         MUL, DIV: begin
            if (coreDone) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   seq_muldiv_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .start     (coreStart),
      .isDiv     (isDiv),
      .opA       (dataA),
      .opB       (dataB),
      .done      (coreDone),
      .divByZero (coreDivZero),
      .result    (coreResult)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         hiReg     <= '0;
         loReg     <= '0;
         Output    <= '0;
         out_valid <= 1'b0;
         div_zero  <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state     <= stateNext;
         out_valid <= 1'b0;
         illegal   <= 1'b0;
         if (accept && isSingle) begin
            Output    <= aluRes;
            out_valid <= 1'b1;
            illegal   <= isIllegal;
         end
         if (accept && isDiv && (dataB != '0)) begin
            div_zero <= 1'b0;
         end
         // Accept and completion are mutually exclusive: the core only
         // finishes while the FSM is out of IDLE.
         if (coreDone) begin
            hiReg     <= coreResult[2*WIDTH-1:WIDTH];
            loReg     <= coreResult[WIDTH-1:0];
            Output    <= '0;
            out_valid <= 1'b1;
            if (coreDivZero) begin
               div_zero <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_muldiv_alu.sv
module tb_seq_muldiv_alu;

   localparam logic [5:0] F_SLL = 6'd0, F_SRL = 6'd2, F_MFHI = 6'd16, F_MFLO = 6'd18;
   localparam logic [5:0] F_MULTU = 6'd25, F_DIVU = 6'd27, F_ADD = 6'd32, F_SUB = 6'd34;
   localparam logic [5:0] F_AND = 6'd36, F_OR = 6'd37, F_SLT = 6'd42;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] dataA = '0;
   logic [31:0] dataB = '0;
   logic [5:0]  Signal = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] Output;
   logic        busy;
   logic        div_zero;
   logic        illegal;

   seq_muldiv_alu #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
      .Output(Output), .busy(busy), .div_zero(div_zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] out;
      logic        ill;
      logic        dz;
   } exp_t;

   exp_t        sb[$];
   int          ovCyc[$];
   int          checks = 0;
   int          errors = 0;

   // Architectural model state.
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;
   logic        mdz = 1'b0;

   logic [5:0]  ops[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   function automatic bit isLegal(input logic [5:0] fn);
      return fn == F_SLL || fn == F_SRL || fn == F_MFHI || fn == F_MFLO || fn == F_MULTU ||
             fn == F_DIVU || fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR || fn == F_SLT;
   endfunction

   // Reference behaviour: what the ISA says each funct does.
   task automatic model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output exp_t e);
      logic [63:0] prod;
      e.out = '0;
      e.ill = 1'b0;
      case (fn)
         F_AND:  e.out = a & b;
         F_OR:   e.out = a | b;
         F_ADD:  e.out = a + b;
         F_SUB:  e.out = a - b;
         F_SLT:  e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         F_SLL:  e.out = a << (b % 32);
         F_SRL:  e.out = a >> (b % 32);
         F_MFHI: e.out = mhi;
         F_MFLO: e.out = mlo;
         F_MULTU: begin
            prod = 64'(a) * 64'(b);
            mhi  = prod[63:32];
            mlo  = prod[31:0];
         end
         F_DIVU: begin
            if (b == 0) begin
               mlo = 32'hFFFF_FFFF;
               mhi = a;
               mdz = 1'b1;
            end else begin
               mlo = a / b;
               mhi = a % b;
               mdz = 1'b0;
            end
         end
         default: e.ill = 1'b1;
      endcase
      e.dz = mdz;
   endtask

   // Present a request, hold it until accepted, push the expected response.
   // acc returns the number of the accepting rising edge.
   task automatic send(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       output int acc);
      int   n;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      Signal   = fn;
      dataA    = a;
      dataB    = b;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout funct=%0d in_ready=%0b required=1", fn, in_ready);
         in_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      model(fn, a, b, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_valid cycle=%0d Output=0x%0h expected=no response",
                        cyc, Output);
            end else begin
               e = sb.pop_front();
               chk("Output", 64'(Output), 64'(e.out));
               chk("illegal", 64'(illegal), 64'(e.ill));
               chk("div_zero", 64'(div_zero), 64'(e.dz));
            end
            ovCyc.push_back(cyc);
         end else begin
            chk("illegal_without_out_valid", 64'(illegal), 64'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout cycle=%0d required=finish", cyc);
      $fatal(1);
   end

   initial begin
      int p0, p1, p2, pm, pa, n, k;
      logic [5:0]  fn;
      logic [31:0] a, b;

      ops = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_SRL, F_MFHI, F_MFLO, F_MULTU, F_DIVU};

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_Output", 64'(Output), 64'd0);
      chk("rst_div_zero", 64'(div_zero), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      reset = 1'b1;
      chk("rst_in_ready_after_release", 64'(in_ready), 64'd1);

      // Wrapping ADD/SUB and signed SLT, back-to-back.
      send(F_ADD, 32'hFFFF_FFFF, 32'd1, p0);
      send(F_SUB, 32'd0, 32'd1, p1);
      send(F_SLT, 32'hFFFF_FFFF, 32'd1, p2);
      repeat (2) @(negedge clk);
      chk("b2b_accept_span", 64'(p2 - p0), 64'd2);
      chk("b2b_ov0", 64'(ovCyc[ovCyc.size()-3]), 64'(p0));
      chk("b2b_ov2", 64'(ovCyc[ovCyc.size()-1]), 64'(p2));

      // Full-scale MULTU: busy for exactly WIDTH cycles.
      send(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, pm);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk("mul_busy_cycles", 64'(n), 64'd32);
      chk("mul_done_in_ready", 64'(in_ready), 64'd1);
      chk("mul_done_out_valid", 64'(out_valid), 64'd1);
      send(F_MFHI, 32'd0, 32'd0, p0);
      send(F_MFLO, 32'd0, 32'd0, p0);

      // DIVU normal then by zero.
      send(F_DIVU, 32'd100, 32'd7, p0);
      send(F_MFLO, 32'd0, 32'd0, p0);
      send(F_MFHI, 32'd0, 32'd0, p0);
      repeat (2) @(negedge clk);
      chk("div_zero_clear", 64'(div_zero), 64'd0);
      send(F_DIVU, 32'd5, 32'd0, p0);
      send(F_MFLO, 32'd0, 32'd0, p0);
      send(F_MFHI, 32'd0, 32'd0, p0);
      repeat (2) @(negedge clk);
      chk("div_zero_set", 64'(div_zero), 64'd1);

      // Shift amount uses only the low bits of dataB.
      send(F_SLL, 32'd1, 32'h23, p0);
      send(F_SRL, 32'h8000_0000, 32'd31, p0);

      // Request held during busy is taken exactly when in_ready rises.
      send(F_MULTU, 32'd3, 32'd4, pm);
      send(F_AND, 32'hF0F0_1234, 32'hFF00_FF0F, pa);
      repeat (2) @(negedge clk);
      chk("held_accept_edge", 64'(pa - pm), 64'd33);
      chk("mul_done_edge", 64'(ovCyc[ovCyc.size()-2]), 64'(pm + 32));
      send(F_MFLO, 32'd0, 32'd0, p0);

      // Unknown funct leaves HI/LO alone.
      send(6'd63, 32'h1234_5678, 32'h9ABC_DEF0, p0);
      send(F_MFHI, 32'd0, 32'd0, p0);
      send(F_MFLO, 32'd0, 32'd0, p0);

      // Reset mid-MULTU aborts without committing.
      send(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, pm);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      mhi = '0;
      mlo = '0;
      mdz = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      repeat (40) @(negedge clk);
      send(F_MFHI, 32'd0, 32'd0, p0);
      send(F_MFLO, 32'd0, 32'd0, p0);

      // Randomized traffic against the model.
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 11);
         if (k == 11) begin
            fn = 6'($urandom_range(0, 63));
            while (isLegal(fn)) fn = 6'($urandom_range(0, 63));
         end else begin
            fn = ops[k];
         end
         a = $urandom;
         b = $urandom;
         if (fn == F_DIVU) begin
            case ($urandom_range(0, 3))
               0: b = 32'd0;
               1: b = $urandom_range(1, 255);
               default: ;
            endcase
         end
         send(fn, a, b, p0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
